// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial port: MMIO addresses, FSM states and
// the SC register readback layout.
package serial_link_pkg;

    localparam logic [15:0] MMIO_SB = 16'hFF01;
    localparam logic [15:0] MMIO_SC = 16'hFF02;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Unimplemented SC bits read back as 1.
    function automatic logic [7:0] sc_value(input logic start, input logic int_clk);
        return {start, 6'b111111, int_clk};
    endfunction

endpackage

// File: rtl/serial_clock_gen.sv
// Serial bit clock source: internal half-period divider or synchronised
// external clock, reduced to single-cycle fall/rise strobes.
module serial_clock_gen #(
    parameter int CLK_DIV = 512
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic int_mode,
    input  logic sclk_in,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic          int_fall, int_rise, ext_fall, ext_rise;

    always_comb begin
        div_d = div_q;
        if (clear || !run)
            div_d = '0;
        else if (div_q == DW'(CLK_DIV - 1))
            div_d = '0;
        else
            div_d = div_q + 1'b1;
    end

    // Sync flops idle high so leaving reset never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sync_q <= {sync_q[0], sclk_in};
            prev_q <= sync_q[1];
        end
    end

    assign int_fall = (div_q == '0);
    assign int_rise = (div_q == DW'(HALF));
    assign ext_fall = prev_q & ~sync_q[1];
    assign ext_rise = ~prev_q & sync_q[1];

    assign fall_tick = run & ~clear & (int_mode ? int_fall : ext_fall);
    assign rise_tick = run & ~clear & (int_mode ? int_rise : ext_rise);

endmodule

// File: rtl/serial_link.sv
// Game Boy serial port: SB/SC registers on the shared bus, 8-bit MSB-first
// shifter clocked internally or externally, one-cycle completion interrupt.
module serial_link
    import serial_link_pkg::*;
#(
    parameter int CLK_DIV = 512
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [15:0] addr_ext,
    inout  wire  [7:0]  data_ext,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        sin,
    input  logic        sclk_in,
    output logic        sout,
    output logic        sclk_out,
    output logic        serial_interrupt
);

    state_e     state_q, state_d;
    logic [7:0] sb_q, sb_d;
    logic       start_q, start_d;
    logic       int_q, int_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sout_q, sout_d;
    logic       sclk_q, sclk_d;
    logic       irq_q, irq_d;

    logic       sel_sb, sel_sc, wr_sb, wr_sc, run;
    logic       fall_tick, rise_tick;
    logic [7:0] rdata;

    assign sel_sb = (addr_ext == MMIO_SB);
    assign sel_sc = (addr_ext == MMIO_SC);
    assign wr_sb  = mem_we & sel_sb & ~start_q;
    assign wr_sc  = mem_we & sel_sc;
    assign run    = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);

    serial_clock_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .clear     (wr_sc),
        .int_mode  (int_q),
        .sclk_in   (sclk_in),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    always_comb begin
        state_d = state_q;
        sb_d    = sb_q;
        start_d = start_q;
        int_d   = int_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        sclk_d  = sclk_q;
        irq_d   = 1'b0;

        // An SC write overrides any shift or completion in the same cycle.
        if (wr_sc) begin
            start_d = data_ext[7];
            int_d   = data_ext[0];
            cnt_d   = '0;
            sclk_d  = 1'b1;
            state_d = data_ext[7] ? ST_SHIFT_LO : ST_IDLE;
        end else begin
            if (wr_sb)
                sb_d = data_ext;
            case (state_q)
                ST_SHIFT_LO, ST_SHIFT_HI: begin
                    if (rise_tick) begin
                        sb_d    = {sb_q[6:0], sin};
                        cnt_d   = cnt_q + 4'd1;
                        sclk_d  = 1'b1;
                        state_d = (cnt_q == 4'd7) ? ST_DONE : ST_SHIFT_HI;
                    end else if (fall_tick) begin
                        sout_d  = sb_q[7];
                        sclk_d  = ~int_q;
                        state_d = ST_SHIFT_LO;
                    end
                end
                ST_DONE: begin
                    start_d = 1'b0;
                    irq_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sb_q    <= 8'h00;
            start_q <= 1'b0;
            int_q   <= 1'b0;
            cnt_q   <= '0;
            sout_q  <= 1'b1;
            sclk_q  <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            start_q <= start_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            sclk_q  <= sclk_d;
            irq_q   <= irq_d;
        end
    end

    assign rdata    = sel_sb ? sb_q : sc_value(start_q, int_q);
    assign data_ext = (mem_re && (sel_sb || sel_sc)) ? rdata : 8'hzz;

    assign sout             = sout_q;
    assign sclk_out         = sclk_q;
    assign serial_interrupt = irq_q;

endmodule

// File: tb/tb_serial_link.sv
// Directed bench for serial_link with CLK_DIV=4.
module tb_serial_link;

    localparam logic [15:0] A_SB = 16'hFF01;
    localparam logic [15:0] A_SC = 16'hFF02;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addr_drv;
    logic [7:0]  data_drv;
    logic        drv_en;
    logic        mem_re, mem_we;
    logic        sin_val, loop_en, sclk_in;
    wire  [15:0] addr_ext;
    wire  [7:0]  data_ext;
    wire         sin;
    logic        sout, sclk_out, serial_interrupt;

    int errors = 0;
    int checks = 0;
    int irq_cnt = 0;

    assign addr_ext = addr_drv;
    assign data_ext = drv_en ? data_drv : 8'hzz;
    assign sin      = loop_en ? sout : sin_val;

    serial_link #(.CLK_DIV(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .addr_ext         (addr_ext),
        .data_ext         (data_ext),
        .mem_re           (mem_re),
        .mem_we           (mem_we),
        .sin              (sin),
        .sclk_in          (sclk_in),
        .sout             (sout),
        .sclk_out         (sclk_out),
        .serial_interrupt (serial_interrupt)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (serial_interrupt) irq_cnt++;

    task bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        addr_drv = a; data_drv = d; drv_en = 1'b1; mem_we = 1'b1;
        @(posedge clock); #1;
        mem_we = 1'b0; drv_en = 1'b0;
    endtask

    task bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clock);
        addr_drv = a; mem_re = 1'b1;
        #1 d = data_ext;
        mem_re = 1'b0;
    endtask

    task test_reset;
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rst_sout: got %b want 1", sout); end
        checks++; if (sclk_out !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b want 1", sclk_out); end
        checks++; if (serial_interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", serial_interrupt); end
        @(negedge clock) reset = 1'b0;
        bus_read(A_SB, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_sb: got %h want 00", d); end
        bus_read(A_SC, d);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL rst_sc: got %h want 7e", d); end
    endtask

    task test_loopback;
        logic [7:0] d, bits;
        int irq_at, c0;
        bits = 8'h00; irq_at = 0;
        bus_write(A_SB, 8'hA5);
        loop_en = 1'b1;
        bus_write(A_SC, 8'h81);
        c0 = irq_cnt;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clock); #1;
            if (serial_interrupt && irq_at == 0) irq_at = i;
            if ((i - 1) % 4 == 0 && i <= 29) bits = {bits[6:0], sout};
        end
        loop_en = 1'b0;
        checks++; if (irq_at !== 32) begin errors++; $display("FAIL loop_irq_time: got %0d want 32", irq_at); end
        checks++; if (irq_cnt - c0 !== 1) begin errors++; $display("FAIL loop_irq_count: got %0d want 1", irq_cnt - c0); end
        checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL loop_sout: got %h want a5", bits); end
        bus_read(A_SB, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL loop_sb: got %h want a5", d); end
        bus_read(A_SC, d);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL loop_sc: got %h want 7f", d); end
    endtask

    task test_receive;
        logic [7:0] d;
        int sclk_bad, sout_bad;
        sclk_bad = 0; sout_bad = 0;
        sin_val = 1'b1;
        bus_write(A_SB, 8'h00);
        bus_write(A_SC, 8'h81);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clock); #1;
            if (sclk_out !== (((i - 1) % 4) >= 2)) sclk_bad++;
            if ((i - 1) % 4 == 0 && sout !== 1'b0) sout_bad++;
        end
        repeat (4) @(posedge clock);
        checks++; if (sclk_bad !== 0) begin errors++; $display("FAIL rx_sclk_pattern: got %0d bad cycles want 0", sclk_bad); end
        checks++; if (sout_bad !== 0) begin errors++; $display("FAIL rx_sout_zero: got %0d bad bits want 0", sout_bad); end
        bus_read(A_SB, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rx_sb: got %h want ff", d); end
    endtask

    task test_external;
        logic [7:0] d, bits;
        int c0;
        bits = 8'h00;
        sin_val = 1'b0;
        bus_write(A_SB, 8'h3C);
        bus_write(A_SC, 8'h80);
        c0 = irq_cnt;
        for (int i = 0; i < 8; i++) begin
            sclk_in = 1'b0;
            repeat (5) @(posedge clock);
            #1 bits = {bits[6:0], sout};
            sclk_in = 1'b1;
            repeat (5) @(posedge clock);
        end
        repeat (10) @(posedge clock);
        checks++; if (bits !== 8'h3C) begin errors++; $display("FAIL ext_sout: got %h want 3c", bits); end
        checks++; if (irq_cnt - c0 !== 1) begin errors++; $display("FAIL ext_irq_count: got %0d want 1", irq_cnt - c0); end
        bus_read(A_SB, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ext_sb: got %h want 00", d); end
        bus_read(A_SC, d);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL ext_sc: got %h want 7e", d); end
        // Edges with start=0 must not shift.
        bus_write(A_SB, 8'h96);
        sin_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sclk_in = 1'b0; repeat (5) @(posedge clock);
            sclk_in = 1'b1; repeat (5) @(posedge clock);
        end
        bus_read(A_SB, d);
        checks++; if (d !== 8'h96) begin errors++; $display("FAIL ext_idle_sb: got %h want 96", d); end
    endtask

    task test_abort_restart;
        logic [7:0] d;
        int c0;
        sin_val = 1'b1;
        bus_write(A_SB, 8'h00);
        bus_write(A_SC, 8'h81);
        c0 = irq_cnt;
        // Shifts at N+3/7/11; abort at N+14 while sclk is low.
        repeat (13) @(posedge clock);
        bus_write(A_SC, 8'h01);
        checks++; if (sclk_out !== 1'b1) begin errors++; $display("FAIL abort_sclk_now: got %b want 1", sclk_out); end
        repeat (30) @(posedge clock);
        checks++; if (irq_cnt - c0 !== 0) begin errors++; $display("FAIL abort_no_irq: got %0d want 0", irq_cnt - c0); end
        checks++; if (sclk_out !== 1'b1) begin errors++; $display("FAIL abort_sclk_idle: got %b want 1", sclk_out); end
        bus_read(A_SB, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL abort_sb_partial: got %h want 07", d); end
        bus_read(A_SC, d);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL abort_sc: got %h want 7f", d); end
        bus_write(A_SC, 8'h81);
        repeat (40) @(posedge clock);
        checks++; if (irq_cnt - c0 !== 1) begin errors++; $display("FAIL restart_irq_count: got %0d want 1", irq_cnt - c0); end
        bus_read(A_SB, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL restart_sb: got %h want ff", d); end
    endtask

    task test_reset_mid;
        logic [7:0] d;
        int c0;
        sin_val = 1'b1;
        bus_write(A_SB, 8'h00);
        bus_write(A_SC, 8'h81);
        c0 = irq_cnt;
        repeat (3) @(posedge clock);
        bus_write(A_SB, 8'h55);
        bus_read(A_SB, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL wprot_sb: got %h want 01", d); end
        // Shift 4 lands at N+19; reset during its low phase.
        repeat (14) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL midrst_sout: got %b want 1", sout); end
        checks++; if (sclk_out !== 1'b1) begin errors++; $display("FAIL midrst_sclk: got %b want 1", sclk_out); end
        @(negedge clock) reset = 1'b0;
        bus_read(A_SB, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_sb: got %h want 00", d); end
        bus_read(A_SC, d);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL midrst_sc: got %h want 7e", d); end
        repeat (40) @(posedge clock);
        checks++; if (irq_cnt - c0 !== 0) begin errors++; $display("FAIL midrst_no_irq: got %0d want 0", irq_cnt - c0); end
        checks++; if (sclk_out !== 1'b1) begin errors++; $display("FAIL midrst_sclk_idle: got %b want 1", sclk_out); end
    endtask

    initial begin
        reset = 1'b1; addr_drv = 16'h0000; data_drv = 8'h00; drv_en = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0; sin_val = 1'b0; loop_en = 1'b0; sclk_in = 1'b1;
        test_reset;
        test_loopback;
        test_receive;
        test_external;
        test_abort_restart;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_link.md
Name: serial_link

Overview:
- Game Boy serial port peripheral on the shared external memory bus, alongside `timers`.
- Implements the SB (0xFF01) and SC (0xFF02) MMIO registers.
- Shifts 8 bits MSB-first using either an internally divided clock or an external clock.
- Raises `serial_interrupt`, which the top level feeds into `IF_in[I_SERIAL]` and `IF_load` of the cpu.

Parameters:
- CLK_DIV, 512: system clocks per serial bit period (4.194 MHz / 8192 Hz). Must be even and >= 2.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- addr_ext  inout  16  shared address bus; sampled only, never driven.
- data_ext  inout  8  shared data bus; driven only during a decoded read, else high-Z.
- mem_re  input  1  bus read strobe.
- mem_we  input  1  bus write strobe.
- sin  input  1  serial data in.
- sclk_in  input  1  external serial clock, asynchronous to clock.
- sout  output  1  serial data out.
- sclk_out  output  1  serial clock out; idles high.
- serial_interrupt  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: SB=0x00, SC.start=0, SC.int=0, sout=1, sclk_out=1, serial_interrupt=0, bit count=0, divider=0, data_ext high-Z.
- Reset asserted mid-transfer aborts the transfer; no interrupt is raised.
- Read path (combinational): while mem_re=1 and addr_ext matches,
  - SB address drives SB.
  - SC address drives {start, 6'b111111, int}.
- Write path: registered on posedge when mem_we=1 and the address matches.
  - SB writes are ignored while start=1.
  - An SC write loads start from data bit 7 and int from data bit 0.
- Transfer start: an SC write with bit 7 = 1.
  - Bit count clears and the divider clears.
  - If a transfer is already active, it restarts from bit 0 with the current SB contents.
- Transfer abort: an SC write with bit 7 = 0 while active stops the transfer immediately.
  - No interrupt; sclk_out returns high; SB keeps its partially shifted value.
- Internal mode (int=1), start written at posedge N:
  - Posedge N+1: sclk_out<=0, sout<=SB[7] (falling phase).
  - After CLK_DIV/2 cycles: sclk_out<=1, SB<={SB[6:0],sin}, count++ (rising phase).
  - After a further CLK_DIV/2 cycles: falling phase again (sclk_out<=0, sout<=new SB[7]).
  - Shift k (k=0..7) happens at posedge N+1+CLK_DIV/2+k*CLK_DIV.
- External mode (int=0):
  - sclk_in passes through a 2-flop synchroniser, then edge detection.
  - Synchronised falling edge: sout<=SB[7].
  - Synchronised rising edge: shift in sin, count++.
  - sclk_out is held at 1 throughout.
  - Edges are ignored while start=0.
- Completion, on the clock after the 8th shift:
  - start<=0 and serial_interrupt=1 for exactly one cycle.
  - sclk_out=1; sout holds its last value.
- Simultaneous events:
  - An SC write in the same cycle as the 8th shift wins: the new start value applies and no interrupt is raised.
  - A CPU read of SB during a transfer returns the partially shifted value.
- State machine:
  - IDLE -> (start write) SHIFT_LO.
  - SHIFT_LO <-> SHIFT_HI, alternating on half-period expiry or external edge.
  - SHIFT_HI with count=8 -> DONE.
  - DONE -> IDLE after one cycle, pulsing the interrupt.
  - Any state -> IDLE on abort write or reset.

Decomposition:
- Add `MMIO_SB` (16'hFF01) and `MMIO_SC` (16'hFF02) to cpu.vh next to the existing MMIO defines.
- Define state encodings as localparams in the module.
- One sub-module, serial_clock_gen:
  - Contains the CLK_DIV half-period counter, the sclk_in synchroniser and the edge detector.
  - Outputs single-cycle `fall_tick` and `rise_tick` strobes.
  - Input `run` enables it; `clear` restarts the divider.
- The top-level testbench adds `mem_re` gating for the SB/SC addresses, the same way it gates the timer addresses.

Test Plan:
- Reset values: reset -> sout=1, sclk_out=1, serial_interrupt=0. Read SB -> 0x00. Read SC -> 0x7E.
- Internal loopback (CLK_DIV=4, sin tied to sout): write SB=0xA5, write SC=0x81 at posedge N.
  - serial_interrupt high only at posedge N+32.
  - SB reads back 0xA5; SC reads 0x7F.
- Internal receive (CLK_DIV=4, sin=1 constant): SB=0x00, SC=0x81.
  - sout emits eight 0s; SB ends at 0xFF.
  - sclk_out shows 8 low/high pairs of 2 cycles each.
- External mode: write SB=0x3C, SC=0x80; drive sclk_in at 1/10 of clock with sin=0.
  - sout bit sequence is 0,0,1,1,1,1,0,0; SB ends at 0x00; one interrupt pulse.
  - sclk_in toggled while SC.start=0 leaves SB unchanged.
- Abort and restart: start an internal transfer, write SC=0x01 after 3 shifts -> no interrupt, sclk_out=1.
  - Then write SC=0x81 -> a full 8-bit transfer and exactly one interrupt.
- Reset mid-transfer, plus write protection: reset asserted during shift 4 -> all reset values and no interrupt.
  - A write of SB=0x55 during an active transfer is ignored.
